pq_shiftq: RTL and testbench

Parametrised successor to `quickq`: a sorted shift-register priority queue of `DEPTH` entries, each a `KEY_W`-bit key plus `DATA_W`-bit payload. It is selectable min- or max-first, stable among equal keys, and supports enqueue and dequeue in the same cycle, including when full. It sits behind the `pq_if` bench harness in the same way `quickq` does and replaces it where width, depth or ordering must be configured.

---
 rtl/pq_pkg.sv | 26 ++
 rtl/pq_if.sv | 28 ++
 rtl/pq_cell.sv | 94 +++++++++
 rtl/pq_shiftq.sv | 126 ++++++++++++
 tb/tb_pq_shiftq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pq_pkg.sv
// Shared types, defaults and the key-ordering helper for the shift-register priority queue.
package pq_pkg;
  typedef enum logic {PQ_MIN = 1'b0, PQ_MAX = 1'b1} pq_mode_t;

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_SHIFT_L  = 3'd1,
    OP_SHIFT_R  = 3'd2,
    OP_LOAD_NEW = 3'd3,
    OP_CLEAR    = 3'd4
  } slot_op_t;

  localparam int PQ_KEY_W_DEF  = 16;
  localparam int PQ_DATA_W_DEF = 16;
  localparam int PQ_KEY_W_MAX  = 64;

  // Strict compare: equal keys are never better, so equal keys leave in arrival order.
  function automatic logic pq_better(input logic [PQ_KEY_W_MAX-1:0] a,
                                     input logic [PQ_KEY_W_MAX-1:0] b,
                                     input pq_mode_t mode);
    logic res;
    if (mode == PQ_MAX) res = (a > b);
    else                res = (a < b);
    return res;
  endfunction
endpackage

// File: rtl/pq_if.sv
// Bundle of pq_shiftq signals; dev and tb modports mirror the queue's port list.
interface pq_if #(
  parameter int DEPTH  = 16,
  parameter int KEY_W  = pq_pkg::PQ_KEY_W_DEF,
  parameter int DATA_W = pq_pkg::PQ_DATA_W_DEF
) (
  input logic clk
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              rst;
  logic              enq_valid;
  logic              enq_ready;
  logic [KEY_W-1:0]  enq_key;
  logic [DATA_W-1:0] enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [KEY_W-1:0]  deq_key;
  logic [DATA_W-1:0] deq_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport dev (input clk, rst, enq_valid, enq_key, enq_data, deq_ready,
               output enq_ready, deq_valid, deq_key, deq_data, count, full, empty);
  modport tb  (input clk, enq_ready, deq_valid, deq_key, deq_data, count, full, empty,
               output rst, enq_valid, enq_key, enq_data, deq_ready);
endinterface

// File: rtl/pq_cell.sv
// One queue slot: holds {vld,key,data}, applies the per-slot op and reports whether
// the incoming key belongs at or before this slot in the post-operation view.
module pq_cell
  import pq_pkg::*;
#(
  parameter int       KEY_W  = PQ_KEY_W_DEF,
  parameter int       DATA_W = PQ_DATA_W_DEF,
  parameter pq_mode_t MODE   = PQ_MIN
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_t          i_op,
  input  logic              i_deq_fire,
  input  logic              i_left_vld,
  input  logic [KEY_W-1:0]  i_left_key,
  input  logic [DATA_W-1:0] i_left_data,
  input  logic              i_right_vld,
  input  logic [KEY_W-1:0]  i_right_key,
  input  logic [DATA_W-1:0] i_right_data,
  input  logic [KEY_W-1:0]  i_new_key,
  input  logic [DATA_W-1:0] i_new_data,
  output logic              o_vld,
  output logic [KEY_W-1:0]  o_key,
  output logic [DATA_W-1:0] o_data,
  output logic              o_better
);
  logic              r_vld;
  logic [KEY_W-1:0]  r_key;
  logic [DATA_W-1:0] r_data;
  logic              w_view_vld;
  logic [KEY_W-1:0]  w_view_key;

  // With a concurrent dequeue the slot compares against what will shift into it.
  always_comb begin
    w_view_vld = r_vld;
    w_view_key = r_key;
    if (i_deq_fire) begin
      w_view_vld = i_right_vld;
      w_view_key = i_right_key;
    end else begin
      w_view_vld = r_vld;
      w_view_key = r_key;
    end
  end

  assign o_better = !w_view_vld |
                    pq_better(PQ_KEY_W_MAX'(i_new_key), PQ_KEY_W_MAX'(w_view_key), MODE);

  // Slot register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_key  <= '0;
      r_data <= '0;
    end else begin
      case (i_op)
        OP_HOLD: begin
          r_vld  <= r_vld;
          r_key  <= r_key;
          r_data <= r_data;
        end
        OP_SHIFT_L: begin
          r_vld  <= i_right_vld;
          r_key  <= i_right_key;
          r_data <= i_right_data;
        end
        OP_SHIFT_R: begin
          r_vld  <= i_left_vld;
          r_key  <= i_left_key;
          r_data <= i_left_data;
        end
        OP_LOAD_NEW: begin
          r_vld  <= 1'b1;
          r_key  <= i_new_key;
          r_data <= i_new_data;
        end
        OP_CLEAR: begin
          r_vld  <= 1'b0;
          r_key  <= '0;
          r_data <= '0;
        end
        default: begin
          r_vld  <= r_vld;
          r_key  <= r_key;
          r_data <= r_data;
        end
      endcase
    end
  end

  assign o_vld  = r_vld;
  assign o_key  = r_key;
  assign o_data = r_data;
endmodule

// File: rtl/pq_shiftq.sv
// Sorted shift-register priority queue, min- or max-first, FIFO-stable among equal keys,
// with single-cycle enqueue+dequeue even when full.
module pq_shiftq
  import pq_pkg::*;
#(
  parameter int       DEPTH  = 16,
  parameter int       KEY_W  = PQ_KEY_W_DEF,
  parameter int       DATA_W = PQ_DATA_W_DEF,
  parameter pq_mode_t MODE   = PQ_MIN,
  localparam int      CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [KEY_W-1:0]  enq_key,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [KEY_W-1:0]  deq_key,
  output logic [DATA_W-1:0] deq_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  logic              w_vld  [DEPTH];
  logic [KEY_W-1:0]  w_key  [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];
  slot_op_t          w_op   [DEPTH];
  logic [DEPTH-1:0]  w_better;
  logic [DEPTH-1:0]  w_first;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic [CNT_W-1:0]  r_count;

  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign deq_valid  = w_vld[0];
  assign w_deq_fire = w_vld[0] & deq_ready;
  assign enq_ready  = !full | w_deq_fire;
  assign w_enq_fire = enq_valid & enq_ready;
  assign deq_key    = w_key[0];
  assign deq_data   = w_data[0];
  assign count      = r_count;

  // Compare vector is monotone (sorted storage), so the insertion slot is its first set bit.
  assign w_first = w_better & ~{w_better[DEPTH-2:0], 1'b0};

  // Per-slot op select from the fire signals and the insertion point.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_op[i] = OP_HOLD;
      if (w_enq_fire && w_deq_fire) begin
        if (!w_better[i])     w_op[i] = OP_SHIFT_L;
        else if (w_first[i])  w_op[i] = OP_LOAD_NEW;
        else                  w_op[i] = OP_HOLD;
      end else if (w_deq_fire) begin
        w_op[i] = (i == DEPTH - 1) ? OP_CLEAR : OP_SHIFT_L;
      end else if (w_enq_fire) begin
        if (!w_better[i])     w_op[i] = OP_HOLD;
        else if (w_first[i])  w_op[i] = OP_LOAD_NEW;
        else                  w_op[i] = OP_SHIFT_R;
      end else begin
        w_op[i] = OP_HOLD;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_enq_fire && !w_deq_fire) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_enq_fire && w_deq_fire) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic              w_lv, w_rv;
    logic [KEY_W-1:0]  w_lk, w_rk;
    logic [DATA_W-1:0] w_ld, w_rd;

    if (g == 0) begin : g_left_edge
      assign w_lv = 1'b0;
      assign w_lk = '0;
      assign w_ld = '0;
    end else begin : g_left
      assign w_lv = w_vld[g-1];
      assign w_lk = w_key[g-1];
      assign w_ld = w_data[g-1];
    end

    if (g == DEPTH - 1) begin : g_right_edge
      assign w_rv = 1'b0;
      assign w_rk = '0;
      assign w_rd = '0;
    end else begin : g_right
      assign w_rv = w_vld[g+1];
      assign w_rk = w_key[g+1];
      assign w_rd = w_data[g+1];
    end

    pq_cell #(.KEY_W(KEY_W), .DATA_W(DATA_W), .MODE(MODE)) u_cell (
      .clk          (clk),
      .rst          (rst),
      .i_op         (w_op[g]),
      .i_deq_fire   (w_deq_fire),
      .i_left_vld   (w_lv),
      .i_left_key   (w_lk),
      .i_left_data  (w_ld),
      .i_right_vld  (w_rv),
      .i_right_key  (w_rk),
      .i_right_data (w_rd),
      .i_new_key    (enq_key),
      .i_new_data   (enq_data),
      .o_vld        (w_vld[g]),
      .o_key        (w_key[g]),
      .o_data       (w_data[g]),
      .o_better     (w_better[g])
    );
  end
endmodule

// File: tb/tb_pq_shiftq.sv
// Self-checking bench for pq_shiftq: directed tables on small min/max queues and a
// randomized run on a wide, deep queue against an unsorted-list reference model.
module tb_pq_shiftq;
  import pq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4 min-first queue
  logic        a_ev, a_er, a_dv, a_dr, a_full, a_empty;
  logic [15:0] a_key, a_data, a_dk, a_dd;
  logic [2:0]  a_cnt;
  // DEPTH=4 max-first queue
  logic        m_ev, m_er, m_dv, m_dr, m_full, m_empty;
  logic [15:0] m_key, m_data, m_dk, m_dd;
  logic [2:0]  m_cnt;
  // DEPTH=32, 32-bit key min-first queue
  logic        b_ev, b_er, b_dv, b_dr, b_full, b_empty;
  logic [31:0] b_key, b_dk;
  logic [15:0] b_data, b_dd;
  logic [5:0]  b_cnt;

  pq_shiftq #(.DEPTH(4), .KEY_W(16), .DATA_W(16), .MODE(PQ_MIN)) u_min (
    .clk(clk), .rst(rst), .enq_valid(a_ev), .enq_ready(a_er), .enq_key(a_key),
    .enq_data(a_data), .deq_valid(a_dv), .deq_ready(a_dr), .deq_key(a_dk),
    .deq_data(a_dd), .count(a_cnt), .full(a_full), .empty(a_empty));

  pq_shiftq #(.DEPTH(4), .KEY_W(16), .DATA_W(16), .MODE(PQ_MAX)) u_max (
    .clk(clk), .rst(rst), .enq_valid(m_ev), .enq_ready(m_er), .enq_key(m_key),
    .enq_data(m_data), .deq_valid(m_dv), .deq_ready(m_dr), .deq_key(m_dk),
    .deq_data(m_dd), .count(m_cnt), .full(m_full), .empty(m_empty));

  pq_shiftq #(.DEPTH(32), .KEY_W(32), .DATA_W(16), .MODE(PQ_MIN)) u_wide (
    .clk(clk), .rst(rst), .enq_valid(b_ev), .enq_ready(b_er), .enq_key(b_key),
    .enq_data(b_data), .deq_valid(b_dv), .deq_ready(b_dr), .deq_key(b_dk),
    .deq_data(b_dd), .count(b_cnt), .full(b_full), .empty(b_empty));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ev;
    logic [15:0] key;
    logic [15:0] data;
    logic        dr;
    logic        rdy;
    logic        dv;
    logic [15:0] hk;
    logic [15:0] hd;
    int          cnt;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic ev, input int key, input int data, input logic dr,
                              input logic rdy, input logic dv, input int hk, input int hd,
                              input int cnt);
    vec_t v;
    v.ev = ev; v.key = 16'(key); v.data = 16'(data); v.dr = dr;
    v.rdy = rdy; v.dv = dv; v.hk = 16'(hk); v.hd = 16'(hd); v.cnt = cnt;
    return v;
  endfunction

  task automatic step_max(input logic ev, input int key, input logic dr,
                          input logic exp_rdy, input logic exp_dv, input int exp_hk,
                          input int exp_cnt);
    @(negedge clk);
    m_ev = ev; m_key = 16'(key); m_data = 16'(key + 256); m_dr = dr;
    #1;
    chk("max_enq_ready", 64'(m_er), 64'(exp_rdy));
    @(posedge clk); #1;
    chk("max_deq_valid", 64'(m_dv), 64'(exp_dv));
    chk("max_head_key",  64'(m_dk), 64'(exp_hk));
    chk("max_head_data", 64'(m_dd), exp_dv ? 64'(exp_hk + 256) : 64'd0);
    chk("max_count",     64'(m_cnt), 64'(exp_cnt));
  endtask

  initial begin
    logic [31:0] mq_key  [$];
    logic [15:0] mq_data [$];
    int          seq;

    rst = 1'b1;
    a_ev = 1'b0; a_key = 16'd0; a_data = 16'd0; a_dr = 1'b0;
    m_ev = 1'b0; m_key = 16'd0; m_data = 16'd0; m_dr = 1'b0;
    b_ev = 1'b0; b_key = 32'd0; b_data = 16'd0; b_dr = 1'b0;

    // Reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", 64'(a_cnt), 64'd0);
    chk("rst_empty", 64'(a_empty), 64'd1);
    chk("rst_full",  64'(a_full), 64'd0);
    chk("rst_deq_valid", 64'(a_dv), 64'd0);
    chk("rst_deq_key",   64'(a_dk), 64'd0);
    chk("rst_deq_data",  64'(a_dd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_enq_ready", 64'(a_er), 64'd1);

    //            ev key data dr  rdy dv hk hd cnt
    tbl[0]  = mk(0, 0, 0,    1,  1, 0, 0, 0,    0);  // deq_ready on empty
    tbl[1]  = mk(1, 7, 'hA,  0,  1, 1, 7, 'hA,  1);
    tbl[2]  = mk(1, 3, 'hB,  0,  1, 1, 3, 'hB,  2);
    tbl[3]  = mk(1, 9, 'hC,  0,  1, 1, 3, 'hB,  3);
    tbl[4]  = mk(1, 3, 'hD,  0,  1, 1, 3, 'hB,  4);
    tbl[5]  = mk(1, 5, 'hE,  0,  0, 1, 3, 'hB,  4);  // full, rejected
    tbl[6]  = mk(0, 0, 0,    1,  1, 1, 3, 'hD,  3);
    tbl[7]  = mk(0, 0, 0,    1,  1, 1, 7, 'hA,  2);
    tbl[8]  = mk(0, 0, 0,    1,  1, 1, 9, 'hC,  1);
    tbl[9]  = mk(0, 0, 0,    1,  1, 0, 0, 0,    0);
    tbl[10] = mk(1, 4, 1,    0,  1, 1, 4, 1,    1);
    tbl[11] = mk(1, 6, 2,    0,  1, 1, 4, 1,    2);
    tbl[12] = mk(1, 8, 3,    0,  1, 1, 4, 1,    3);
    tbl[13] = mk(1, 2, 4,    0,  1, 1, 2, 4,    4);
    tbl[14] = mk(1, 1, 5,    0,  0, 1, 2, 4,    4);  // full, no pop
    tbl[15] = mk(1, 1, 5,    1,  1, 1, 1, 5,    4);  // full, pop+push
    tbl[16] = mk(0, 0, 0,    1,  1, 1, 4, 1,    3);
    tbl[17] = mk(1, 5, 6,    1,  1, 1, 5, 6,    3);
    tbl[18] = mk(1, 5, 7,    0,  1, 1, 5, 6,    4);  // equal key goes behind
    tbl[19] = mk(0, 0, 0,    1,  1, 1, 5, 7,    3);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_ev = tbl[i].ev; a_key = tbl[i].key; a_data = tbl[i].data; a_dr = tbl[i].dr;
      #1;
      chk("min_enq_ready", 64'(a_er), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      chk("min_deq_valid", 64'(a_dv), 64'(tbl[i].dv));
      chk("min_head_key",  64'(a_dk), 64'(tbl[i].hk));
      chk("min_head_data", 64'(a_dd), 64'(tbl[i].hd));
      chk("min_count",     64'(a_cnt), 64'(tbl[i].cnt));
      chk("min_full",      64'(a_full), 64'(tbl[i].cnt == 4));
      chk("min_empty",     64'(a_empty), 64'(tbl[i].cnt == 0));
    end
    @(negedge clk);
    a_ev = 1'b0; a_dr = 1'b0;

    // Max-first simultaneous enqueue/dequeue
    step_max(1, 5, 0, 1, 1, 5, 1);
    step_max(1, 2, 0, 1, 1, 5, 2);
    step_max(1, 9, 1, 1, 1, 9, 2);
    step_max(1, 1, 1, 1, 1, 2, 2);
    step_max(0, 0, 1, 1, 1, 1, 1);
    step_max(0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    m_ev = 1'b0; m_dr = 1'b0;

    // Randomized run against an unsorted arrival-ordered list
    seq = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int pe, pd, best, sz;
      logic dfire, efire;
      pe = ((cyc / 1000) % 2 == 0) ? 75 : 35;
      pd = ((cyc / 1000) % 2 == 0) ? 40 : 75;
      @(negedge clk);
      b_ev = ($urandom_range(0, 99) < pe);
      b_dr = ($urandom_range(0, 99) < pd);
      b_key = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      b_data = 16'(seq);
      #1;
      sz = mq_key.size();
      best = 0;
      for (int k = 1; k < sz; k++)
        if (mq_key[k] < mq_key[best]) best = k;
      dfire = (sz > 0) && b_dr;
      efire = b_ev && ((sz < 32) || dfire);
      chk("rnd_enq_ready", 64'(b_er), 64'((sz < 32) || dfire));
      chk("rnd_deq_valid", 64'(b_dv), 64'(sz > 0));
      chk("rnd_head_key",  64'(b_dk), (sz > 0) ? 64'(mq_key[best]) : 64'd0);
      chk("rnd_head_data", 64'(b_dd), (sz > 0) ? 64'(mq_data[best]) : 64'd0);
      @(posedge clk); #1;
      if (dfire) begin
        mq_key.delete(best);
        mq_data.delete(best);
      end
      if (efire) begin
        mq_key.push_back(b_key);
        mq_data.push_back(b_data);
        seq++;
      end
      chk("rnd_count", 64'(b_cnt), 64'(mq_key.size()));
    end
    @(negedge clk);
    b_ev = 1'b0; b_dr = 1'b0;

    // Reset on the same edge as an enqueue while u_min holds three entries
    #1;
    chk("pre_rst_count", 64'(a_cnt), 64'd3);
    @(negedge clk);
    a_ev = 1'b1; a_key = 16'd0; a_data = 16'h77; a_dr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_count", 64'(a_cnt), 64'd0);
    chk("midrst_deq_valid", 64'(a_dv), 64'd0);
    chk("midrst_deq_key", 64'(a_dk), 64'd0);
    @(negedge clk);
    rst = 1'b0; a_ev = 1'b0;
    #1;
    chk("midrst_enq_ready", 64'(a_er), 64'd1);
    @(posedge clk); #1;
    chk("midrst_not_retained", 64'(a_dv), 64'd0);
    chk("midrst_empty", 64'(a_empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
